y86_seq_ctrl: RTL

- Parametrised multi-cycle sequencer for the Y86-64 core.
- Steps FETCH→DECODE→EXECUTE→MEMORY→WRITE_BACK→UPDATE_PC, with a req/ack memory handshake, a memory-wait timeout and an instruction register.
- Also owns the PC, the retired-instruction counter and processor status (AOK/HLT/ADR/INS).
- Sits between the ram, fetch, decode/regs and PC-select logic in the CPU top.

---
 rtl/y86_pkg.sv | 65 ++++++
 rtl/y86_seq_ctrl_if.sv | 22 ++
 rtl/y86_mem_wait_timer.sv | 33 +++
 rtl/y86_seq_ctrl.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 multi-cycle sequencer: sequencer states,
// processor status codes, the icodes the sequencer cares about, and helpers
// that classify an instruction's memory behaviour.
package y86_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEMORY,
        S_WRITE_BACK,
        S_UPDATE_PC,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        STAT_AOK = 2'b00,
        STAT_HLT = 2'b01,
        STAT_ADR = 2'b10,
        STAT_INS = 2'b11
    } stat_e;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    // Instruction register contents captured at the end of FETCH.
    typedef struct packed {
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } ir_t;

    function automatic logic needs_mem(logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_MRMOVQ) || (icode == I_CALL) ||
               (icode == I_RET)    || (icode == I_PUSHQ)  || (icode == I_POPQ);
    endfunction

    function automatic logic mem_writes(logic [3:0] icode);
        return (icode == I_RMMOVQ) || (icode == I_CALL) || (icode == I_PUSHQ);
    endfunction

    function automatic logic [5:0] stage_onehot(state_e s);
        logic [5:0] oh;
        oh = 6'b000000;
        case (s)
            S_FETCH:      oh = 6'b000001;
            S_DECODE:     oh = 6'b000010;
            S_EXECUTE:    oh = 6'b000100;
            S_MEMORY:     oh = 6'b001000;
            S_WRITE_BACK: oh = 6'b010000;
            S_UPDATE_PC:  oh = 6'b100000;
            default:      oh = 6'b000000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/y86_seq_ctrl_if.sv
// Memory request/acknowledge bus between the sequencer (master) and the
// instruction/data RAM (slave).
interface y86_seq_ctrl_if #(
    parameter int ADDR_W = 64
);
    logic              mem_req;
    logic              mem_we;
    logic              mem_ifetch;
    logic [ADDR_W-1:0] mem_addr_o;
    logic              mem_ack;
    logic              mem_err;

    modport master (
        output mem_req, mem_we, mem_ifetch, mem_addr_o,
        input  mem_ack, mem_err
    );

    modport slave (
        input  mem_req, mem_we, mem_ifetch, mem_addr_o,
        output mem_ack, mem_err
    );
endinterface

// File: rtl/y86_mem_wait_timer.sv
// Counts request cycles that go unanswered and flags expiry on the cycle that
// would reach WAIT_MAX. An ack in that same cycle suppresses expiry.
// WAIT_MAX = 0 removes the counter and never expires.
module y86_mem_wait_timer #(
    parameter int WAIT_MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic active,
    input  logic ack,
    output logic expire
);
    generate
        if (WAIT_MAX == 0) begin : g_off
            logic unused_in;
            assign unused_in = ^{clk, rst_n, clr, active, ack};
            assign expire    = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(WAIT_MAX + 1);
            logic [CW-1:0] cnt;

            // Count waiting cycles; any state change restarts the count.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)              cnt <= '0;
                else if (clr)            cnt <= '0;
                else if (active && !ack) cnt <= cnt + CW'(1);
            end

            assign expire = active && !ack && (cnt == CW'(WAIT_MAX - 1));
        end
    endgenerate
endmodule

// File: rtl/y86_seq_ctrl.sv
// Y86-64 multi-cycle sequencer: FETCH -> DECODE -> EXECUTE -> [MEMORY] ->
// WRITE_BACK -> UPDATE_PC, owning PC, instruction register, retired count
// and processor status. HALT is terminal until reset.
// Optional feature macro: Y86_SINGLE_STEP_EN (adds step_i; each step pulse
// releases exactly one instruction fetch).
module y86_seq_ctrl
    import y86_pkg::*;
#(
    parameter int                ADDR_W   = 64,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                WAIT_MAX = 8,
    parameter int                CNT_W    = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    y86_seq_ctrl_if.master    bus,
`ifdef Y86_SINGLE_STEP_EN
    input  logic              step_i,
`endif
    input  logic [3:0]        icode_i,
    input  logic [3:0]        ifun_i,
    input  logic [3:0]        rA_i,
    input  logic [3:0]        rB_i,
    input  logic [63:0]       valC_i,
    input  logic [63:0]       valP_i,
    input  logic              instr_valid_i,
    input  logic [ADDR_W-1:0] exe_addr_i,
    input  logic [ADDR_W-1:0] new_pc_i,
    output logic [3:0]        icode_o,
    output logic [3:0]        ifun_o,
    output logic [3:0]        rA_o,
    output logic [3:0]        rB_o,
    output logic [63:0]       valC_o,
    output logic [63:0]       valP_o,
    output logic [5:0]        stage_o,
    output logic              wb_en,
    output logic [ADDR_W-1:0] pc_o,
    output logic [1:0]        stat_o,
    output logic [CNT_W-1:0]  retired_o
);
    state_e            state, state_d;
    stat_e             stat, stat_d;
    ir_t               ir;
    logic              ir_load;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  retired;
    logic              fetch_go, req, expire, state_chg;

`ifdef Y86_SINGLE_STEP_EN
    logic token;
    // One buffered step token; consumed when a fetch completes into DECODE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) token <= 1'b0;
        else        token <= (token && !(state == S_FETCH && state_d == S_DECODE)) || step_i;
    end
    assign fetch_go = token;
`else
    assign fetch_go = 1'b1;
`endif

    // Reset drops the request combinationally so an in-flight access is abandoned at once.
    assign req = rst_n && (((state == S_FETCH) && fetch_go) || (state == S_MEMORY));

    assign bus.mem_req    = req;
    assign bus.mem_ifetch = rst_n && (state == S_FETCH) && fetch_go;
    assign bus.mem_we     = rst_n && (state == S_MEMORY) && mem_writes(ir.icode);
    assign bus.mem_addr_o = (state == S_MEMORY) ? exe_addr_i : pc;

    assign state_chg = (state_d != state);

    y86_mem_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state_chg),
        .active (req),
        .ack    (bus.mem_ack),
        .expire (expire)
    );

    // Next-state and fault recording; faults always land in HALT, so only the first is kept.
    always_comb begin
        state_d = state;
        stat_d  = stat;
        ir_load = 1'b0;
        case (state)
            S_FETCH: begin
                if (req && bus.mem_ack) begin
                    if (bus.mem_err) begin
                        state_d = S_HALT; stat_d = STAT_ADR;
                    end else if (!instr_valid_i) begin
                        state_d = S_HALT; stat_d = STAT_INS;
                    end else begin
                        state_d = S_DECODE; ir_load = 1'b1;
                    end
                end else if (expire) begin
                    state_d = S_HALT; stat_d = STAT_ADR;
                end
            end
            S_DECODE:  state_d = S_EXECUTE;
            S_EXECUTE: state_d = needs_mem(ir.icode) ? S_MEMORY : S_WRITE_BACK;
            S_MEMORY: begin
                if (bus.mem_ack) begin
                    if (bus.mem_err) begin
                        state_d = S_HALT; stat_d = STAT_ADR;
                    end else begin
                        state_d = S_WRITE_BACK;
                    end
                end else if (expire) begin
                    state_d = S_HALT; stat_d = STAT_ADR;
                end
            end
            S_WRITE_BACK: state_d = S_UPDATE_PC;
            S_UPDATE_PC: begin
                if (ir.icode == I_HALT) begin
                    state_d = S_HALT; stat_d = STAT_HLT;
                end else begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_HALT;
        endcase
    end

    // State, status, instruction register, PC and retired count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            stat    <= STAT_AOK;
            ir      <= '0;
            pc      <= RESET_PC;
            retired <= '0;
        end else begin
            state <= state_d;
            stat  <= stat_d;
            if (ir_load) ir <= '{icode: icode_i, ifun: ifun_i, ra: rA_i, rb: rB_i,
                                 valc: valC_i, valp: valP_i};
            if (state == S_UPDATE_PC) begin
                pc      <= (ir.icode == I_HALT) ? ADDR_W'(ir.valp) : new_pc_i;
                retired <= retired + CNT_W'(1);
            end
        end
    end

    assign icode_o   = ir.icode;
    assign ifun_o    = ir.ifun;
    assign rA_o      = ir.ra;
    assign rB_o      = ir.rb;
    assign valC_o    = ir.valc;
    assign valP_o    = ir.valp;
    assign stage_o   = stage_onehot(state);
    assign wb_en     = (state == S_WRITE_BACK);
    assign pc_o      = pc;
    assign stat_o    = stat;
    assign retired_o = retired;
endmodule
